spi_slave_if: RTL and testbench

SPI slave interface that consumes the `sclk`/`cs`/`mosi` lines produced by the team's SPI master and returns `miso`. It oversamples all SPI inputs on the system clock, supports all four CPOL/CPHA modes selected at runtime, and delivers received words over a valid/ready handshake. It also serialises a transmit word onto `miso`. It sits directly downstream of the master's SCLK generator and MOSI shifter.

---
 rtl/spi_slave_if.sv | 203 ++++++++++++++++++++
 tb/tb_spi_slave_if.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI slave for all four CPOL/CPHA modes. The SPI lines are
//            oversampled on clk. Received words are delivered over a
//            valid/ready handshake, and tx_data is serialised onto miso.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            cpol, cpha        - SPI mode, latched when cs falls
//            sclk, cs, mosi    - asynchronous SPI inputs (cs active-low)
//            miso, miso_oe     - slave data out and its tri-state enable
//            rx_data, rx_valid - received word and its valid flag
//            rx_ready          - consumer accept
//            rx_overrun        - pulse when an unconsumed word is overwritten
//            tx_data, tx_req   - transmit word; tx_req pulses while it is sampled
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    r_sclk_d;
  logic                    r_cs_d;
  logic [SYNC_STAGES:0]    r_flush;
  logic                    r_armed;
  logic                    r_cpol;
  logic                    r_cpha;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_sh;
  logic [DATA_WIDTH-1:0]   r_tx_sh;
  logic                    r_skip;
  logic                    r_reload;
  logic                    r_done;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_rise, w_fall, w_sample_edge, w_shift_edge;
  logic w_cs_fall, w_start, w_do_sample, w_do_shift;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_rise = w_sclk_s & ~r_sclk_d;
  assign w_fall = ~w_sclk_s & r_sclk_d;

  // Sample on the leading edge for CPHA=0 and on the trailing edge for CPHA=1,
  // which reduces to rising when cpol == cpha.
  assign w_sample_edge = (r_cpol == r_cpha) ? w_rise : w_fall;
  assign w_shift_edge  = (r_cpol == r_cpha) ? w_fall : w_rise;

  // The synchronisers reset to the cs idle level, so for a few cycles after
  // reset w_cs_s shows a high that never existed on the pin. A frame may start
  // only after the chain has flushed and a genuine high has been seen.
  assign w_cs_fall = r_armed & r_cs_d & ~w_cs_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_do_sample  = 1'b0;
    w_do_shift   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_next_state = ST_ACTIVE;
          w_start      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_s) begin
          w_next_state = ST_IDLE;
        end else begin
          w_do_sample = w_sample_edge;
          w_do_shift  = w_shift_edge;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    miso_oe = (r_state == ST_ACTIVE);
    miso    = (r_state == ST_ACTIVE) & r_tx_sh[DATA_WIDTH-1];
    // tx_data is sampled at the cs fall and at the first shift edge after
    // each word wraps.
    tx_req  = w_start | (w_do_shift & r_reload & ~r_skip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush     <= '0;
      r_armed     <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_skip      <= 1'b0;
      r_reload    <= 1'b0;
      r_done      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed     <= r_armed | (r_flush[SYNC_STAGES] & w_cs_s);
      r_done      <= 1'b0;

      if (w_start) begin
        r_cpol    <= cpol;
        r_cpha    <= cpha;
        r_tx_sh   <= tx_data;
        // With CPHA=1 the MSB is already on miso, so the first shift edge
        // only confirms it.
        r_skip    <= cpha;
        r_reload  <= 1'b0;
        r_bit_cnt <= '0;
      end else if ((r_state == ST_ACTIVE) && w_cs_s) begin
        // Frame aborted or finished: any partial word is dropped.
        r_bit_cnt <= '0;
        r_skip    <= 1'b0;
        r_reload  <= 1'b0;
      end else begin
        if (w_do_sample) begin
          r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], w_mosi_s};
          if (r_bit_cnt == c_last_bit) begin
            r_bit_cnt <= '0;
            r_done    <= 1'b1;
            r_reload  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        if (w_do_shift) begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (r_reload) begin
            r_tx_sh  <= tx_data;
            r_reload <= 1'b0;
          end else begin
            r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end

      // Word delivery is one cycle behind the final sample so that the
      // completed shifter contents are stable when copied.
      rx_overrun <= 1'b0;
      if (r_done) begin
        rx_data    <= r_rx_sh;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_if
// Purpose  : Self-checking bench for spi_slave_if. A behavioural SPI master
//            drives frames, and expected received words go into a queue that
//            a negedge monitor pops on each accepted rx word.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, sclk, cs, mosi, rx_ready;
  logic       miso, miso_oe, rx_valid, rx_overrun, tx_req;
  logic [7:0] rx_data, tx_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_ovr    = 0;
  int         n_txreq  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  logic [15:0] cap;
  int         snap;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_req(tx_req)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: a word is consumed when rx_valid && rx_ready before a posedge.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
      end else begin
        exp_word = exp_q.pop_front();
        check("rx_word", {24'd0, rx_data}, {24'd0, exp_word});
      end
    end
    if (rx_overrun) n_ovr++;
    if (tx_req) n_txreq++;
  end

  // SPI master. miso is captured one half-period after each sample edge,
  // which leaves room for the slave's synchroniser latency.
  task automatic spi_xfer(input logic pol, input logic pha, input logic [15:0] bits,
                          input int nbits, input bit chk_start, input bit keep_cs,
                          output logic [15:0] captured);
    captured = '0;
    sclk = pol;
    cpol = pol;
    cpha = pha;
    wait_cycles(4);
    cs   = 1'b0;
    mosi = pha ? 1'b0 : bits[15];
    if (chk_start) begin
      wait_cycles(2);
      check("oe_before_latency", {31'd0, miso_oe}, 32'd0);
      wait_cycles(1);
      check("oe_at_latency", {31'd0, miso_oe}, 32'd1);
      wait_cycles(1);
      check("msb_before_first_edge", {31'd0, miso}, {31'd0, tx_data[7]});
    end else begin
      wait_cycles(4);
    end
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        sclk = ~pol;
        wait_cycles(H);
        captured = {captured[14:0], miso};
        sclk = pol;
        if (i + 1 < nbits) mosi = bits[14-i];
        wait_cycles(H);
      end else begin
        sclk = ~pol;
        mosi = bits[15-i];
        wait_cycles(H);
        sclk = pol;
        wait_cycles(H);
        captured = {captured[14:0], miso};
      end
    end
    wait_cycles(2);
    if (!keep_cs) cs = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; rx_ready = 1'b1; tx_data = 8'h00;
    @(posedge clk);
    #2;
    wait_cycles(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    wait_cycles(8);

    // Mode 0 single word.
    tx_data = 8'hC3;
    exp_q.push_back(8'hA5);
    spi_xfer(1'b0, 1'b0, 16'hA500, 8, 1'b1, 1'b0, cap);
    check("mode0_master_rx", {24'd0, cap[7:0]}, 32'hC3);
    wait_cycles(10);

    // Mode 3, two back-to-back words under one cs.
    tx_data = 8'h96;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    snap = n_txreq;
    spi_xfer(1'b1, 1'b1, 16'h1234, 16, 1'b0, 1'b0, cap);
    wait_cycles(10);
    check("mode3_tx_req_pulses", n_txreq - snap, 32'd2);
    check("mode3_master_rx", {16'd0, cap}, 32'h9696);

    // Modes 1 and 2.
    tx_data = 8'h3C;
    exp_q.push_back(8'h5A);
    spi_xfer(1'b0, 1'b1, 16'h5A00, 8, 1'b0, 1'b0, cap);
    check("mode1_master_rx", {24'd0, cap[7:0]}, 32'h3C);
    wait_cycles(10);
    tx_data = 8'hE1;
    exp_q.push_back(8'h5A);
    spi_xfer(1'b1, 1'b0, 16'h5A00, 8, 1'b0, 1'b0, cap);
    check("mode2_master_rx", {24'd0, cap[7:0]}, 32'hE1);
    wait_cycles(10);

    // Partial word aborted by cs, then a full frame.
    tx_data = 8'h00;
    spi_xfer(1'b0, 1'b0, 16'hF800, 5, 1'b0, 1'b0, cap);
    wait_cycles(10);
    check("partial_no_valid", {31'd0, rx_valid}, 32'd0);
    tx_data = 8'h55;
    exp_q.push_back(8'hF0);
    spi_xfer(1'b0, 1'b0, 16'hF000, 8, 1'b0, 1'b0, cap);
    wait_cycles(10);

    // Overrun with rx_ready held low.
    rx_ready = 1'b0;
    snap = n_ovr;
    spi_xfer(1'b0, 1'b0, 16'h1100, 8, 1'b0, 1'b0, cap);
    wait_cycles(10);
    spi_xfer(1'b0, 1'b0, 16'h2200, 8, 1'b0, 1'b0, cap);
    wait_cycles(10);
    check("overrun_pulses", n_ovr - snap, 32'd1);
    check("overrun_rx_data", {24'd0, rx_data}, 32'h22);
    check("overrun_rx_valid", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back(8'h22);
    rx_ready = 1'b1;
    wait_cycles(1);
    check("accept_clears_valid", {31'd0, rx_valid}, 32'd0);

    // Reset mid-frame with cs held low.
    spi_xfer(1'b0, 1'b0, 16'hFF00, 3, 1'b0, 1'b1, cap);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
    check("midrst_tx_req", {31'd0, tx_req}, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(10);
    check("no_start_on_low_cs", {31'd0, miso_oe}, 32'd0);
    cs = 1'b1;
    wait_cycles(8);
    exp_q.push_back(8'h81);
    spi_xfer(1'b0, 1'b0, 16'h8100, 8, 1'b0, 1'b0, cap);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cycles(1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
